// File: rtl/led_pkg.sv
// Shared LED driver definitions: global mode encoding.
// Optional breathe mode is enabled by LED_BREATHE_EN.
package led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    LED_STATIC  = 2'd0,
    LED_BLINK   = 2'd1,
    LED_PWM     = 2'd2,
    LED_BREATHE = 2'd3
  } led_mode_e;

endpackage

// File: rtl/led_prescaler.sv
// Prescaler: one-cycle tick every TICK_DIV clk cycles.
// Counts 0..TICK_DIV-1 and restarts.
module led_prescaler
  import led_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/led_driver_pwm.sv
// Multi-channel LED driver: static, blink, PWM dim modes.
// Define LED_BREATHE_EN to make mode 3 a breathe ramp.
module led_driver_pwm
  import led_pkg::*;
#(
  parameter int N_LEDS      = 4,
  parameter int PWM_BITS    = 8,
  parameter int TICK_DIV    = 1000,
  parameter int BLINK_TICKS = 250,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_LEDS-1:0]   led_in,
  input  logic [MODE_W-1:0]   mode,
  input  logic [PWM_BITS-1:0] duty,
  output logic [N_LEDS-1:0]   led_out,
  output logic                period_start
);

  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic                tick;
  logic                wrap;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                bound_q, bound_d;
  led_mode_e           mode_q, mode_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                blink_ph_q, blink_ph_d;
  logic [N_LEDS-1:0]   led_out_q, led_out_d;
  logic                pstart_q, pstart_d;
  logic [N_LEDS-1:0]   act;
`ifdef LED_BREATHE_EN
  logic [PWM_BITS-1:0] level_q, level_d;
  logic                dir_up_q, dir_up_d;
`endif

  function automatic logic pwm_on(
    input logic [PWM_BITS-1:0] d,
    input logic [PWM_BITS-1:0] c
  );
    if (d == '0) begin
      return 1'b0;
    end else if (d == PWM_MAX) begin
      return 1'b1;
    end else begin
      return c < d;
    end
  endfunction

  led_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Settings latch on the wrap edge so a period never mixes modes.
  always_comb begin
    wrap      = (pwm_cnt_q == PWM_MAX);
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    bound_d   = wrap;
    pstart_d  = bound_q;
    mode_d    = mode_q;
    duty_d    = duty_q;
    if (wrap) begin
      mode_d = led_mode_e'(mode);
      duty_d = duty;
    end
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
`ifdef LED_BREATHE_EN
    level_d  = level_q;
    dir_up_d = dir_up_q;
    if (tick) begin
      if (dir_up_q) begin
        if (level_q == PWM_MAX) begin
          dir_up_d = 1'b0;
          level_d  = level_q - PWM_BITS'(1);
        end else begin
          level_d  = level_q + PWM_BITS'(1);
        end
      end else begin
        if (level_q == '0) begin
          dir_up_d = 1'b1;
          level_d  = PWM_BITS'(1);
        end else begin
          level_d  = level_q - PWM_BITS'(1);
        end
      end
    end
`endif
  end

  always_comb begin
    act = led_in;
    unique case (1'b1)
      (mode_q == LED_BLINK): begin
        act = led_in & {N_LEDS{blink_ph_q}};
      end
      (mode_q == LED_PWM): begin
        act = led_in & {N_LEDS{pwm_on(duty_q, pwm_cnt_q)}};
      end
`ifdef LED_BREATHE_EN
      (mode_q == LED_BREATHE): begin
        act = led_in & {N_LEDS{pwm_on(level_q, pwm_cnt_q)}};
      end
`endif
      default: begin
        act = led_in;
      end
    endcase
    led_out_d = act ^ {N_LEDS{ACTIVE_LOW}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q   <= '0;
      bound_q     <= 1'b0;
      mode_q      <= LED_STATIC;
      duty_q      <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b1;
      led_out_q   <= {N_LEDS{ACTIVE_LOW}};
      pstart_q    <= 1'b0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      bound_q     <= bound_d;
      mode_q      <= mode_d;
      duty_q      <= duty_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      led_out_q   <= led_out_d;
      pstart_q    <= pstart_d;
    end
  end

`ifdef LED_BREATHE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q  <= '0;
      dir_up_q <= 1'b1;
    end else begin
      level_q  <= level_d;
      dir_up_q <= dir_up_d;
    end
  end
`endif

  assign led_out      = led_out_q;
  assign period_start = pstart_q;

endmodule
